// File: rtl/tx_pkt_arbiter.sv
// Packet-level arbiter: shares one CMAC TX AXI-Stream among NUM_SRC requesters,
// holding a grant from first beat to tlast, with a 2-entry registered skid buffer on the output.
module tx_pkt_arbiter #(
    parameter int                 C_AXIS_DATA_WIDTH = 512,
    parameter int                 C_AXIS_KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8,
    parameter int                 NUM_SRC           = 4,
    parameter logic [NUM_SRC-1:0] HIPRI_MASK        = NUM_SRC'(4'b0101)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_SRC*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_SRC*C_AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]                     s_axis_tvalid,
    input  logic [NUM_SRC-1:0]                     s_axis_tlast,
    output logic [NUM_SRC-1:0]                     s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
    output logic [C_AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    output logic                                   m_axis_tlast,
    input  logic                                   m_axis_tready,
    output logic [2:0]                             grant_id,
    output logic                                   busy
);
    localparam int         DW       = C_AXIS_DATA_WIDTH;
    localparam int         KW       = C_AXIS_KEEP_WIDTH;
    localparam int         SW       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [2:0] LAST_SRC = 3'(NUM_SRC - 1);
    localparam logic [3:0] NSRC4    = 4'(NUM_SRC);

    typedef enum logic {IDLE, XFER} state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    state_t        state_q;
    logic [2:0]    grant_q;
    logic [2:0]    rr_q;
    logic          busy_q;
    beat_t         ent0_q, ent0_d, ent1_q, ent1_d;
    logic          v0_q, v0_d, v1_q, v1_d;

    beat_t             src_beat [NUM_SRC];
    beat_t             in_beat;
    logic [SW-1:0]     grant_idx;
    logic [NUM_SRC-1:0] cand;
    logic [2*NUM_SRC-1:0] cand_rot;
    logic [2:0]        off;
    logic [3:0]        win_sum;
    logic [2:0]        win;
    logic              xfer, accept, pop;

    assign xfer      = (state_q == XFER);
    assign grant_idx = grant_q[SW-1:0];
    assign in_beat   = src_beat[grant_idx];
    // Full skid buffer (second entry occupied) is the only source of back-pressure.
    assign accept    = xfer && !v1_q && s_axis_tvalid[grant_idx];
    assign pop       = v0_q && m_axis_tready;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_beat[i] = '{data: s_axis_tdata[i*DW +: DW],
                               keep: s_axis_tkeep[i*KW +: KW],
                               last: s_axis_tlast[i]};
        assign s_axis_tready[i] = xfer && !v1_q && (grant_idx == SW'(i));
    end

    // Rotate candidates so bit 0 is rr_q; the lowest set bit is the winner's offset.
    always_comb begin
        cand     = ((s_axis_tvalid & HIPRI_MASK) != '0) ? (s_axis_tvalid & HIPRI_MASK)
                                                        : s_axis_tvalid;
        cand_rot = {cand, cand} >> rr_q;
        off      = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand_rot[k]) off = 3'(k);
        end
        win_sum = {1'b0, rr_q} + {1'b0, off};
        if (win_sum >= NSRC4) win_sum = win_sum - NSRC4;
        win = win_sum[2:0];
    end

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        if (accept && (!v0_q || pop)) begin
            ent0_d = in_beat;
            v0_d   = 1'b1;
        end else if (accept) begin
            ent1_d = in_beat;
            v1_d   = 1'b1;
        end else if (pop) begin
            if (v1_q) begin
                ent0_d = ent1_q;
                v1_d   = 1'b0;
            end else begin
                v0_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            busy_q  <= 1'b0;
            ent0_q  <= '0;
            ent1_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            v0_q   <= v0_d;
            v1_q   <= v1_d;
            case (state_q)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_q <= win;
                        busy_q  <= 1'b1;
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (accept && in_beat.last) begin
                        rr_q    <= (grant_q == LAST_SRC) ? 3'd0 : grant_q + 3'd1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = ent0_q.data;
    assign m_axis_tkeep  = ent0_q.keep;
    assign m_axis_tlast  = ent0_q.last;
    assign m_axis_tvalid = v0_q;
    assign grant_id      = grant_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tx_pkt_arbiter.sv
// Randomized-data bench for tx_pkt_arbiter: queue-based source drivers, an output
// scoreboard and a spec-level arbitration model decide the expected stream and grant order.
module tb_tx_pkt_arbiter;
    localparam int         DW     = 64;
    localparam int         KW     = 8;
    localparam int         NS     = 4;
    localparam logic [3:0] HIMASK = 4'b0101;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*DW-1:0]  s_tdata = '0;
    logic [NS*KW-1:0]  s_tkeep = '0;
    logic [NS-1:0]     s_tvalid = '0, s_tlast = '0, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tvalid, m_tlast, m_tready = 1'b1;
    logic [2:0]        grant_id;
    logic              busy;

    logic [NS*DW-1:0]  r_s_tdata = '0;
    logic [NS*KW-1:0]  r_s_tkeep = '1;
    logic [NS-1:0]     r_s_tvalid = '0, r_s_tlast = '0, r_s_tready;
    logic [DW-1:0]     r_m_tdata;
    logic [KW-1:0]     r_m_tkeep;
    logic              r_m_tvalid, r_m_tlast, r_m_tready = 1'b1;
    logic [2:0]        r_grant_id;
    logic              r_busy;

    always #5 clk = ~clk;

    tx_pkt_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_KEEP_WIDTH(KW), .NUM_SRC(NS)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .grant_id(grant_id), .busy(busy)
    );

    tx_pkt_arbiter #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_KEEP_WIDTH(KW), .NUM_SRC(NS),
                     .HIPRI_MASK(4'b0000)) dut_rr (
        .clk(clk), .rst(rst),
        .s_axis_tdata(r_s_tdata), .s_axis_tkeep(r_s_tkeep), .s_axis_tvalid(r_s_tvalid),
        .s_axis_tlast(r_s_tlast), .s_axis_tready(r_s_tready),
        .m_axis_tdata(r_m_tdata), .m_axis_tkeep(r_m_tkeep), .m_axis_tvalid(r_m_tvalid),
        .m_axis_tlast(r_m_tlast), .m_axis_tready(r_m_tready),
        .grant_id(r_grant_id), .busy(r_busy)
    );

    int    n_cmp = 0, n_err = 0, cyc = 0, occ = 0, model_rr = 0, low_run = 0;
    bit    bp_mode = 0, chk_occ = 0, saw_full = 0;
    logic  busy_prev = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    beat_t srcq [NS][$];
    beat_t pend [NS][$];
    beat_t expq[$], gotq[$];
    int    grantq[$], expg[$], gapq[$];

    // Reference arbitration: high-priority requests win if any, then first from rr upward.
    function automatic int model_pick(input logic [3:0] req, input int rr, input logic [3:0] mask);
        logic [3:0] c;
        int idx;
        c = ((req & mask) != 4'b0) ? (req & mask) : req;
        for (int k = 0; k < NS; k++) begin
            idx = (rr + k) % NS;
            if (c[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    task automatic add_pkt(input int src, input int n);
        beat_t b;
        logic [63:0] r;
        for (int i = 0; i < n; i++) begin
            r   = {$urandom, $urandom};
            b.d = {src[7:0], i[7:0], r[47:0]};
            b.k = (i == n - 1) ? (r[55:48] | 8'h01) : 8'hff;
            b.l = (i == n - 1);
            srcq[src].push_back(b);
            pend[src].push_back(b);
        end
    endtask

    task automatic commit(input int src);
        while (pend[src].size() > 0) expq.push_back(pend[src].pop_front());
        expg.push_back(src);
        model_rr = (src + 1) % NS;
    endtask

    task automatic clear_q();
        expq.delete(); gotq.delete(); grantq.delete(); expg.delete(); gapq.delete();
    endtask

    function automatic bit src_pending();
        for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive queue heads at negedge, sample at negedge+1, log handshakes due at next posedge.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]          = 1'b1;
                s_tdata[i*DW +: DW]  = srcq[i][0].d;
                s_tkeep[i*KW +: KW]  = srcq[i][0].k;
                s_tlast[i]           = srcq[i][0].l;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        m_tready = bp_mode ? bp_pat[cyc[1:0]] : 1'b1;
        #1;
        if (busy && !busy_prev) begin
            grantq.push_back(int'(grant_id));
            gapq.push_back(low_run);
            low_run = 0;
        end
        if (!busy) low_run++;
        busy_prev = busy;
        if (chk_occ && occ >= 2) begin
            saw_full = 1;
            n_cmp++;
            if (s_tready[2] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_full_tready: got %b required 0 (occupancy %0d)", s_tready[2], occ);
            end
        end
        for (int i = 0; i < NS; i++)
            if (s_tvalid[i] && s_tready[i]) begin
                void'(srcq[i].pop_front());
                occ++;
            end
        if (m_tvalid && m_tready) begin
            gotq.push_back(beat_t'({m_tdata, m_tkeep, m_tlast}));
            occ--;
        end
        cyc++;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((src_pending() || gotq.size() < expq.size() || busy) && t < 1000) begin
            step();
            t++;
        end
        repeat (3) step();
        if (t >= 1000) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got %0d beats required %0d", name, gotq.size(), expq.size());
        end
    endtask

    task automatic test_reset();
        s_tvalid = 4'hf;
        repeat (2) @(negedge clk);
        #1;
        n_cmp += 4;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin
            n_err++; $display("FAIL rst_mvalid_mlast: got %b%b required 00", m_tvalid, m_tlast);
        end
        if (m_tdata !== '0 || m_tkeep !== '0) begin
            n_err++; $display("FAIL rst_mdata: got %h/%h required 0/0", m_tdata, m_tkeep);
        end
        if (grant_id !== 3'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_grant_busy: got %0d/%b required 0/0", grant_id, busy);
        end
        if (s_tready !== 4'h0 || r_m_tvalid !== 1'b0) begin
            n_err++; $display("FAIL rst_tready: got %b required 0000", s_tready);
        end
        s_tvalid = 4'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_src();
        logic [7:0] exp_mv = 8'b0011_1100;
        logic [7:0] exp_bz = 8'b0001_1110;
        int w;
        clear_q();
        add_pkt(3, 4);
        w = model_pick(4'b1000, model_rr, HIMASK);
        commit(w);
        for (int s = 0; s < 8; s++) begin
            step();
            n_cmp += 2;
            if (m_tvalid !== exp_mv[s]) begin
                n_err++; $display("FAIL t1_mvalid[%0d]: got %b required %b", s, m_tvalid, exp_mv[s]);
            end
            if (busy !== exp_bz[s]) begin
                n_err++; $display("FAIL t1_busy[%0d]: got %b required %b", s, busy, exp_bz[s]);
            end
            if (exp_mv[s]) begin
                n_cmp++;
                if (m_tlast !== (s == 5)) begin
                    n_err++; $display("FAIL t1_tlast[%0d]: got %b required %b", s, m_tlast, (s == 5));
                end
            end
            if (s == 1 || s == 4) begin
                n_cmp++;
                if (int'(grant_id) != w) begin
                    n_err++; $display("FAIL t1_grant[%0d]: got %0d required %0d", s, grant_id, w);
                end
            end
        end
        drain("t1");
        n_cmp++;
        if (gotq.size() != expq.size()) begin
            n_err++; $display("FAIL t1_len: got %0d required %0d", gotq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            n_cmp++;
            if (gotq[i] !== expq[i]) begin
                n_err++; $display("FAIL t1_beat%0d: got %h required %h", i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_rr_pair();
        int w1, w2;
        clear_q();
        add_pkt(1, 2);
        add_pkt(3, 2);
        w1 = model_pick(4'b1010, model_rr, HIMASK);
        commit(w1);
        w2 = model_pick(4'b1010 & ~(4'b1 << w1), model_rr, HIMASK);
        commit(w2);
        drain("t2");
        n_cmp++;
        if (gotq.size() != expq.size() || grantq.size() != expg.size()) begin
            n_err++; $display("FAIL t2_len: got %0d/%0d required %0d/%0d",
                              gotq.size(), grantq.size(), expq.size(), expg.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            n_cmp++;
            if (gotq[i] !== expq[i]) begin
                n_err++; $display("FAIL t2_beat%0d: got %h required %h", i, gotq[i], expq[i]);
            end
        end
        for (int i = 0; i < expg.size() && i < grantq.size(); i++) begin
            n_cmp++;
            if (grantq[i] != expg[i]) begin
                n_err++; $display("FAIL t2_grant%0d: got %0d required %0d", i, grantq[i], expg[i]);
            end
        end
        if (gapq.size() > 1) begin
            n_cmp++;
            if (gapq[1] != 1) begin
                n_err++; $display("FAIL t2_idle_gap: got %0d required 1", gapq[1]);
            end
        end
    endtask

    task automatic test_no_preempt();
        int w, t = 0;
        clear_q();
        add_pkt(3, 6);
        commit(model_pick(4'b1000, model_rr, HIMASK));
        while (srcq[3].size() > 4 && t < 50) begin
            step();
            t++;
        end
        add_pkt(0, 2);
        add_pkt(1, 2);
        w = model_pick(4'b0011, model_rr, HIMASK);
        commit(w);
        commit(model_pick(4'b0011 & ~(4'b1 << w), model_rr, HIMASK));
        drain("t3");
        n_cmp++;
        if (gotq.size() != expq.size() || grantq.size() != expg.size()) begin
            n_err++; $display("FAIL t3_len: got %0d/%0d required %0d/%0d",
                              gotq.size(), grantq.size(), expq.size(), expg.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            n_cmp++;
            if (gotq[i] !== expq[i]) begin
                n_err++; $display("FAIL t3_beat%0d: got %h required %h", i, gotq[i], expq[i]);
            end
        end
        for (int i = 0; i < expg.size() && i < grantq.size(); i++) begin
            n_cmp++;
            if (grantq[i] != expg[i]) begin
                n_err++; $display("FAIL t3_grant%0d: got %0d required %0d", i, grantq[i], expg[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_q();
        add_pkt(2, 8);
        commit(model_pick(4'b0100, model_rr, HIMASK));
        bp_mode = 1; chk_occ = 1; saw_full = 0;
        drain("t4");
        bp_mode = 0; chk_occ = 0;
        n_cmp++;
        if (!saw_full || gotq.size() != expq.size()) begin
            n_err++; $display("FAIL t4_len: got %0d beats (full seen %b) required %0d",
                              gotq.size(), saw_full, expq.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            n_cmp++;
            if (gotq[i] !== expq[i]) begin
                n_err++; $display("FAIL t4_beat%0d: got %h required %h", i, gotq[i], expq[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int cnt [NS];
        int rr = 0, got = 0, t = 0, src, w;
        for (int i = 0; i < NS; i++) begin
            cnt[i] = 0;
            r_s_tdata[i*DW +: DW] = DW'(i);
        end
        @(negedge clk);
        r_s_tvalid = 4'hf;
        r_s_tlast  = 4'hf;
        while (got < 100 && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
            if (|r_s_tready) begin
                src = 0;
                for (int i = 0; i < NS; i++) if (r_s_tready[i]) src = i;
                w = model_pick(4'hf, rr, 4'h0);
                n_cmp++;
                if (src != w) begin
                    n_err++; $display("FAIL t5_grant%0d: got %0d required %0d", got, src, w);
                end
                rr = (w + 1) % NS;
                cnt[src]++;
                got++;
            end
        end
        @(posedge clk);
        #1;
        r_s_tvalid = 4'h0;
        if (t >= 1000) begin
            n_cmp++; n_err++; $display("FAIL t5_timeout: got %0d grants required 100", got);
        end
        for (int i = 0; i < NS; i++) begin
            n_cmp++;
            if (cnt[i] < 24 || cnt[i] > 26) begin
                n_err++; $display("FAIL t5_share%0d: got %0d required 25+-1", i, cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        clear_q();
        add_pkt(1, 6);
        while (srcq[1].size() > 4 && t < 50) begin
            step();
            t++;
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tkeep !== '0) begin
            n_err++; $display("FAIL t6_async_m: got v%b l%b d%h k%h required all 0",
                              m_tvalid, m_tlast, m_tdata, m_tkeep);
        end
        if (busy !== 1'b0 || grant_id !== 3'd0) begin
            n_err++; $display("FAIL t6_async_busy: got %b/%0d required 0/0", busy, grant_id);
        end
        if (s_tready !== 4'h0) begin
            n_err++; $display("FAIL t6_async_tready: got %b required 0000", s_tready);
        end
        srcq[1].delete(); pend[1].delete();
        s_tvalid = 4'h0;
        clear_q();
        occ = 0; model_rr = 0; busy_prev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if (gotq.size() != 0) begin
            n_err++; $display("FAIL t6_stale: got %0d beats required 0", gotq.size());
        end
        add_pkt(1, 1);
        add_pkt(3, 1);
        t = model_pick(4'b1010, model_rr, HIMASK);
        commit(t);
        commit(model_pick(4'b1010 & ~(4'b1 << t), model_rr, HIMASK));
        drain("t6");
        n_cmp++;
        if (gotq.size() != expq.size() || grantq.size() != expg.size()) begin
            n_err++; $display("FAIL t6_len: got %0d/%0d required %0d/%0d",
                              gotq.size(), grantq.size(), expq.size(), expg.size());
        end
        for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
            n_cmp++;
            if (gotq[i] !== expq[i]) begin
                n_err++; $display("FAIL t6_beat%0d: got %h required %h", i, gotq[i], expq[i]);
            end
        end
        for (int i = 0; i < expg.size() && i < grantq.size(); i++) begin
            n_cmp++;
            if (grantq[i] != expg[i]) begin
                n_err++; $display("FAIL t6_grant%0d: got %0d required %0d", i, grantq[i], expg[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_rr_pair();
        test_no_preempt();
        test_backpressure();
        test_round_robin();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/tx_pkt_arbiter.md
Name: tx_pkt_arbiter

Overview:
- Packet-level arbiter that shares the single CMAC TX AXI-Stream path among up to NUM_SRC transmit requesters.
- Default requester map: src0 = ARP reply, src1 = RoCE CM, src2 = RoCE ACK/CNP, src3 = RoCE data.
- Once granted, a requester owns the output from its first beat to its tlast beat; beats are never interleaved.
- Output is registered through a 2-entry skid buffer, so full throughput is kept and the CMAC-facing timing path is isolated.

Parameters:
- C_AXIS_DATA_WIDTH, 512, stream data width in bits.
- C_AXIS_KEEP_WIDTH, C_AXIS_DATA_WIDTH/8, tkeep width.
- NUM_SRC, 4, number of requesters (2..8).
- HIPRI_MASK, 4'b0101, bit i set = source i is high priority (ARP and ACK/CNP by default).

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  NUM_SRC*C_AXIS_DATA_WIDTH  source i occupies slice [i*W +: W].
- s_axis_tkeep  in  NUM_SRC*C_AXIS_KEEP_WIDTH  per-source tkeep, same slicing.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tlast  in  NUM_SRC  per-source last.
- s_axis_tready  out  NUM_SRC  per-source ready.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  to CMAC TX.
- m_axis_tkeep  out  C_AXIS_KEEP_WIDTH  to CMAC TX.
- m_axis_tvalid  out  1  to CMAC TX.
- m_axis_tlast  out  1  to CMAC TX.
- m_axis_tready  in  1  from CMAC TX.
- grant_id  out  3  index of the current or most recent owner.
- busy  out  1  high while in XFER.

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-high. Reset is asynchronous assert, synchronous-release usage. While rst is high, or after it, all of the following hold:
  - state = IDLE; s_axis_tready = 0; skid buffer emptied.
  - m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = 0.
  - grant_id = 0, busy = 0, rr_ptr = 0.
- Reset mid-packet: the partial packet is discarded from the skid buffer and is not completed. The requester is responsible for restarting its packet.
- FSM states: IDLE, XFER.
- IDLE:
  - req = s_axis_tvalid. If (req & HIPRI_MASK) != 0, candidates are the high-priority requests only; otherwise all of req.
  - Winner = first candidate found scanning upward from rr_ptr, wrapping modulo NUM_SRC.
  - On any request: register grant_id = winner, go to XFER, set busy = 1.
  - All s_axis_tready stay 0 in IDLE.
- XFER:
  - s_axis_tready[grant_id] = skid buffer not full (fewer than 2 entries). All other s_axis_tready = 0.
  - A beat is accepted when tvalid && tready on source grant_id; it is pushed into the skid buffer.
  - When the accepted beat has tlast: rr_ptr = (grant_id+1) mod NUM_SRC, return to IDLE, busy = 0 the next cycle.
- Skid buffer:
  - 2 entries; entry 0 drives the m_axis registers.
  - Pop on m_axis_tvalid && m_axis_tready.
  - Push and pop in the same cycle: occupancy is unchanged and FIFO order is preserved.
  - Full: tready to the source drops, no beat is lost. Empty: m_axis_tvalid = 0.
- Latency:
  - Source tvalid first high in IDLE at cycle N → grant registered at the N edge; the first beat is accepted in cycle N+1 and appears on m_axis in cycle N+2.
  - With m_axis_tready held high: 1 beat per cycle in XFER.
  - Exactly one idle arbitration cycle between packets.
- The skid buffer may still be draining the previous packet while the next packet is being accepted. Ordering is preserved.
- tdata and tkeep pass through unmodified; no byte reordering.
- A grant is never revoked before tlast, even if a high-priority source raises tvalid.
- A granted source that deasserts tvalid mid-packet stalls the output; the grant is held indefinitely.
- Single-beat packet (tvalid && tlast on the first beat): accepted in the cycle after the grant, then back to IDLE.
- NUM_SRC not a power of two: rr_ptr wraps from NUM_SRC-1 to 0.

Test Plan:
- Reset, then only src3 sends a 4-beat packet with m_axis_tready = 1 → m_axis_tvalid high in cycles N+2..N+5; tlast on the 4th beat; grant_id = 3; busy falls at N+5.
- src1 and src3 assert tvalid together, each with a 2-beat packet, from rr_ptr = 0 → src1 is sent first, then src3 after one idle cycle; rr_ptr ends at 0.
- src3 is mid-transfer (beat 2 of 6) when src0 (high priority) asserts tvalid → src3 completes all 6 beats uninterrupted; src0 is granted next, ahead of a pending src1.
- Back-pressure: m_axis_tready toggles 1,0,0,1,… during an 8-beat src2 packet → the output contains all 8 beats in order with matching tkeep; s_axis_tready[2] is low while the buffer is full; no duplicate or dropped beats.
- All four sources continuously valid with 1-beat packets and no high-priority traffic (HIPRI_MASK = 0) → grant order 0,1,2,3,0,…; each source receives 25% ±1 of grants over 100 packets.
- rst pulsed for 1 cycle in the middle of a src1 packet → all outputs go to 0 asynchronously; the remaining src1 beats are not forwarded before a new grant; the next arbitration starts with rr_ptr = 0.
